// File: rtl/operand_entry_if.sv
// Operand bus from operand_entry to the downstream in1/in2 inputs.
// The consumer samples each operand on its one-cycle valid strobe.
interface operand_entry_if;
    logic [31:0] op1;
    logic        op1_valid;
    logic [31:0] op2;
    logic        op2_valid;

    modport master (output op1, op1_valid, op2, op2_valid);
    modport slave  (input  op1, op1_valid, op2, op2_valid);
endinterface

// File: rtl/operand_entry.sv
// Switch/button operand entry: debounced buttons shift sw nibbles into a work
// register and commit it alternately to op1 and op2 with a one-cycle strobe.
module operand_debounce #(
    parameter int unsigned          CNT_W = 16,
    parameter logic [CNT_W-1:0]     LAST  = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    logic [1:0]       sync;
    logic             level;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync    <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync    <= {sync[0], raw};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Rising edge of the debounced level only; release is ignored.
    assign press = level & ~level_q;
endmodule

module operand_entry #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             sw,
    input  logic                   btn_load,
    input  logic                   btn_commit,
    operand_entry_if.master        ops,
    output logic                   target,
    output logic [3:0]             nib_cnt
);
    typedef enum logic {BUILD_A = 1'b0, BUILD_B = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 16'd1);

    // Lane 0 = load button, lane 1 = commit button.
    logic [1:0] press;
    operand_debounce #(.CNT_W(CNT_W), .LAST(LAST)) u_db [1:0] (
        .clk   (clk),
        .reset (reset),
        .raw   ({btn_commit, btn_load}),
        .press (press)
    );

    wire load   = press[0];
    wire commit = press[1];

    state_t      state, state_n;
    logic [31:0] work, work_n;
    logic [3:0]  cnt_n;
    logic [31:0] op1_n, op2_n;
    logic        v1_n, v2_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= BUILD_A;
            work          <= '0;
            nib_cnt       <= '0;
            ops.op1       <= '0;
            ops.op2       <= '0;
            ops.op1_valid <= 1'b0;
            ops.op2_valid <= 1'b0;
        end else begin
            state         <= state_n;
            work          <= work_n;
            nib_cnt       <= cnt_n;
            ops.op1       <= op1_n;
            ops.op2       <= op2_n;
            ops.op1_valid <= v1_n;
            ops.op2_valid <= v2_n;
        end
    end

    // Commit takes priority; a coincident load is dropped.
    always_comb begin
        state_n = state;
        work_n  = work;
        cnt_n   = nib_cnt;
        op1_n   = ops.op1;
        op2_n   = ops.op2;
        v1_n    = 1'b0;
        v2_n    = 1'b0;
        if (commit) begin
            work_n = '0;
            cnt_n  = '0;
            if (state == BUILD_A) begin
                op1_n   = work;
                v1_n    = 1'b1;
                state_n = BUILD_B;
            end else begin
                op2_n   = work;
                v2_n    = 1'b1;
                state_n = BUILD_A;
            end
        end else if (load) begin
            work_n = {work[27:0], sw};
            if (nib_cnt != 4'd8) cnt_n = nib_cnt + 4'd1;
        end
    end

    assign target = (state == BUILD_B);
endmodule

// File: tb/tb_operand_entry.sv
// Directed plus randomized button sequences against a nibble-queue model.
module tb_operand_entry;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       btn_load, btn_commit;
    logic       target;
    logic [3:0] nib_cnt;

    operand_entry_if ifc ();

    operand_entry #(.DEBOUNCE_CYCLES(16'd4), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .btn_load   (btn_load),
        .btn_commit (btn_commit),
        .ops        (ifc.master),
        .target     (target),
        .nib_cnt    (nib_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: every nibble loaded since the last commit, oldest first.
    logic [3:0]  nibs[$];
    logic        m_target;
    logic [31:0] m_op1, m_op2;
    int          exp_v1, exp_v2;

    // Strobe monitor, sampled on the falling edge.
    int          v1_hi = 0, v2_hi = 0, overlap = 0;
    logic [31:0] v1_val = '0, v2_val = '0;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (ifc.op1_valid) begin v1_hi++; v1_val = ifc.op1; end
            if (ifc.op2_valid) begin v2_hi++; v2_val = ifc.op2; end
            if (ifc.op1_valid && ifc.op2_valid) overlap++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fold();
        logic [63:0] v = '0;
        foreach (nibs[i]) v = v * 64'd16 + 64'(nibs[i]);
        return v[31:0];
    endfunction

    task automatic chk_state(input string tag);
        chk({tag, ".target"}, 32'(target), 32'(m_target));
        chk({tag, ".nib_cnt"}, 32'(nib_cnt), (nibs.size() > 8) ? 32'd8 : 32'(nibs.size()));
        chk({tag, ".op1"}, ifc.op1, m_op1);
        chk({tag, ".op2"}, ifc.op2, m_op2);
    endtask

    task automatic model_reset();
        nibs.delete();
        m_target = 1'b0;
        m_op1 = '0;
        m_op2 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
        step(2);
        model_reset();
    endtask

    // One clean press of load and/or commit, then a clean release.
    task automatic press(input logic l, input logic c, input logic [3:0] nib, input string tag);
        sw = nib;
        btn_load = l;
        btn_commit = c;
        step(10);
        btn_load = 1'b0;
        btn_commit = 1'b0;
        step(10);
        if (c) begin
            if (!m_target) begin m_op1 = fold(); exp_v1++; end
            else begin m_op2 = fold(); exp_v2++; end
            m_target = ~m_target;
            nibs.delete();
        end else if (l) begin
            nibs.push_back(nib);
        end
        chk_state(tag);
        if (c) begin
            chk({tag, ".v1_cycles"}, 32'(v1_hi), 32'(exp_v1));
            chk({tag, ".v2_cycles"}, 32'(v2_hi), 32'(exp_v2));
            if (m_target) chk({tag, ".v1_value"}, v1_val, m_op1);
            else chk({tag, ".v2_value"}, v2_val, m_op2);
        end
    endtask

    initial begin
        reset = 1'b0;
        sw = '0;
        btn_load = 1'b0;
        btn_commit = 1'b0;
        exp_v1 = 0;
        exp_v2 = 0;
        model_reset();
        step(3);
        chk("reset.op1_valid", 32'(ifc.op1_valid), 32'd0);
        chk("reset.op2_valid", 32'(ifc.op2_valid), 32'd0);
        chk_state("reset");
        reset = 1'b1;
        step(2);

        // Reset in the middle of building a three-nibble operand.
        press(1'b1, 1'b0, 4'h1, "pre_rst_ld1");
        press(1'b1, 1'b0, 4'h2, "pre_rst_ld2");
        sw = 4'h3;
        btn_load = 1'b1;
        step(5);
        reset = 1'b0;
        step(1);
        model_reset();
        chk_state("mid_reset");
        btn_load = 1'b0;
        step(3);
        reset = 1'b1;
        step(10);
        chk_state("post_reset");
        chk("post_reset.strobes", 32'(v1_hi + v2_hi), 32'd0);
        press(1'b0, 1'b1, 4'h0, "commit_after_reset");

        // Short glitches must never load.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_load = 1'b1;
            step(1);
            btn_load = 1'b0;
            step(2);
        end
        step(10);
        chk_state("glitch");
        press(1'b1, 1'b0, 4'h5, "held_load");

        do_reset();
        press(1'b1, 1'b0, 4'hD, "dead_ld0");
        press(1'b1, 1'b0, 4'hE, "dead_ld1");
        press(1'b1, 1'b0, 4'hA, "dead_ld2");
        press(1'b1, 1'b0, 4'hD, "dead_ld3");
        press(1'b0, 1'b1, 4'h0, "dead_commit");
        chk("dead.op1", ifc.op1, 32'h0000DEAD);

        for (int i = 1; i <= 10; i++) press(1'b1, 1'b0, 4'(i), "wrap_ld");
        press(1'b0, 1'b1, 4'h0, "wrap_commit");
        chk("wrap.op2", ifc.op2, 32'h3456789A);

        press(1'b0, 1'b1, 4'h0, "empty_commit");
        press(1'b1, 1'b1, 4'hF, "both_commit");
        chk("both.op2", ifc.op2, 32'h0);

        press(1'b0, 1'b1, 4'h0, "b2b_0");
        press(1'b0, 1'b1, 4'h0, "b2b_1");
        press(1'b0, 1'b1, 4'h0, "b2b_2");

        for (int i = 0; i < 60; i++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            press(r >= 2 || r == 1, r <= 1, 4'($urandom), "rand");
        end

        chk("overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
